// File: rtl/park_transform.sv
// rtl/park_transform.sv - Park transform: rotates (alpha, beta) by theta into (d, q), one register stage.
// Quarter-wave sine table is built at elaboration; the quadrant fold derives sin and cos from it.
module park_transform (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [15:0] alpha,
   input  logic signed [15:0] beta,
   input  logic signed [15:0] theta,
   output logic signed [15:0] d,
   output logic signed [15:0] q
);

   // round(16384*sin(k*pi/512)) via a fixed-point Taylor series with 30 fractional bits
   function automatic int sin_entry(input int k);
      longint x;
      longint x2;
      longint term;
      longint acc;
      x    = (longint'(k) * 64'sd3373259426) / 64'sd512;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return int'((acc * 64'sd16384 + (64'sd1 <<< 29)) >>> 30);
   endfunction

   function automatic logic signed [15:0] round_sat(input logic signed [32:0] v);
      logic signed [32:0] r;
      r = (v + 33'sd8192) >>> 14;
      if (r > 33'sd32767)
         return 16'sh7fff;
      else if (r < -33'sd32768)
         return 16'sh8000;
      else
         return r[15:0];
   endfunction

   logic signed [15:0] lut [0:256];

   for (genvar k = 0; k <= 256; k++) begin : g_lut
      localparam int VAL = sin_entry(k);
      assign lut[k] = 16'(VAL);
   end

   logic [8:0]         idx;
   logic [8:0]         idx_c;
   logic signed [15:0] s_i;
   logic signed [15:0] s_c;
   logic signed [15:0] sin_v;
   logic signed [15:0] cos_v;
   logic signed [31:0] p_ac;
   logic signed [31:0] p_bs;
   logic signed [31:0] p_bc;
   logic signed [31:0] p_as;
   logic signed [32:0] d_sum;
   logic signed [32:0] q_sum;

   assign idx   = {1'b0, theta[13:6]};
   assign idx_c = 9'd256 - idx;
   assign s_i   = lut[idx];
   assign s_c   = lut[idx_c];

   always_comb begin
      sin_v = s_i;
      cos_v = s_c;
      case (theta[15:14])
         2'b00: begin sin_v =  s_i; cos_v =  s_c; end
         2'b01: begin sin_v =  s_c; cos_v = -s_i; end
         2'b10: begin sin_v = -s_i; cos_v = -s_c; end
         2'b11: begin sin_v = -s_c; cos_v =  s_i; end
         default: ;
      endcase
   end

   assign p_ac  = alpha * cos_v;
   assign p_bs  = beta * sin_v;
   assign p_bc  = beta * cos_v;
   assign p_as  = alpha * sin_v;
   assign d_sum = 33'(p_ac) + 33'(p_bs);
   assign q_sum = 33'(p_bc) - 33'(p_as);

   // rst_n is active-high despite its name
   always_ff @(posedge clk) begin
      if (rst_n) begin
         d <= '0;
         q <= '0;
      end else begin
         d <= round_sat(d_sum);
         q <= round_sat(q_sum);
      end
   end

endmodule

// File: tb/tb_park_transform.sv
// tb/tb_park_transform.sv - Directed-vector bench for park_transform.
module tb_park_transform;

   logic               clk;
   logic               rst_n;
   logic signed [15:0] alpha;
   logic signed [15:0] beta;
   logic signed [15:0] theta;
   logic signed [15:0] d;
   logic signed [15:0] q;

   integer passed;
   integer total;

   park_transform dut (
      .clk   (clk),
      .rst_n (rst_n),
      .alpha (alpha),
      .beta  (beta),
      .theta (theta),
      .d     (d),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply(input logic r, input logic signed [15:0] a,
                        input logic signed [15:0] b, input logic signed [15:0] t);
      @(negedge clk);
      rst_n = r;
      alpha = a;
      beta  = b;
      theta = t;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 16'sd1234, -16'sd4321, 16'sd0);
         total++;
         if (d !== 16'sd0) $display("FAIL reset_d cycle %0d got %0d want 0", i, d);
         else passed++;
         total++;
         if (q !== 16'sd0) $display("FAIL reset_q cycle %0d got %0d want 0", i, q);
         else passed++;
      end
      apply(1'b0, 16'sd1234, -16'sd4321, 16'sd0);
      total++;
      if (d !== 16'sd1234) $display("FAIL first_valid_d got %0d want 1234", d);
      else passed++;
      total++;
      if (q !== -16'sd4321) $display("FAIL first_valid_q got %0d want -4321", q);
      else passed++;
   endtask

   task automatic test_identity();
      logic signed [15:0] av [6];
      logic signed [15:0] bv [6];
      av = '{16'sd32767, 16'sd0, 16'sd32767, -16'sd32767, 16'sd0, -16'sd32767};
      bv = '{16'sd0, 16'sd32767, 16'sd32767, 16'sd0, -16'sd32767, -16'sd32767};
      for (int i = 0; i < 6; i++) begin
         apply(1'b0, av[i], bv[i], 16'sd0);
         total++;
         if (d !== av[i]) $display("FAIL identity_d set %0d got %0d want %0d", i, d, av[i]);
         else passed++;
         total++;
         if (q !== bv[i]) $display("FAIL identity_q set %0d got %0d want %0d", i, q, bv[i]);
         else passed++;
      end
   endtask

   task automatic test_quarter();
      apply(1'b0, 16'sd1000, 16'sd2000, 16'sd16384);
      total++;
      if (d !== 16'sd2000) $display("FAIL plus90_d got %0d want 2000", d);
      else passed++;
      total++;
      if (q !== -16'sd1000) $display("FAIL plus90_q got %0d want -1000", q);
      else passed++;
      apply(1'b0, 16'sd1000, 16'sd2000, -16'sd16384);
      total++;
      if (d !== -16'sd2000) $display("FAIL minus90_d got %0d want -2000", d);
      else passed++;
      total++;
      if (q !== 16'sd1000) $display("FAIL minus90_q got %0d want 1000", q);
      else passed++;
   endtask

   task automatic test_eighth();
      apply(1'b0, 16'sd32767, 16'sd32767, 16'sd8192);
      total++;
      if (d !== 16'sd32767) $display("FAIL deg45_sat_d got %0d want 32767", d);
      else passed++;
      total++;
      if (q !== 16'sd0) $display("FAIL deg45_sat_q got %0d want 0", q);
      else passed++;
      apply(1'b0, 16'sd1000, 16'sd0, 16'sd8192);
      total++;
      if (d !== 16'sd707) $display("FAIL deg45_d got %0d want 707", d);
      else passed++;
      total++;
      if (q !== -16'sd707) $display("FAIL deg45_q got %0d want -707", q);
      else passed++;
   endtask

   task automatic test_saturation();
      apply(1'b0, 16'sh8000, 16'sd0, 16'sd16384);
      total++;
      if (q !== 16'sd32767) $display("FAIL sat90_q got %0d want 32767", q);
      else passed++;
      total++;
      if (d !== 16'sd0) $display("FAIL sat90_d got %0d want 0", d);
      else passed++;
      apply(1'b0, 16'sh8000, 16'sd100, 16'sh8000);
      total++;
      if (d !== 16'sd32767) $display("FAIL sat180_d got %0d want 32767", d);
      else passed++;
      total++;
      if (q !== -16'sd100) $display("FAIL sat180_q got %0d want -100", q);
      else passed++;
   endtask

   task automatic test_midstream_reset();
      apply(1'b0, 16'sd111, 16'sd222, 16'sd0);
      total++;
      if (d !== 16'sd111 || q !== 16'sd222)
         $display("FAIL mid_before got d=%0d q=%0d want d=111 q=222", d, q);
      else passed++;
      apply(1'b1, 16'sd333, 16'sd444, 16'sd0);
      total++;
      if (d !== 16'sd0 || q !== 16'sd0)
         $display("FAIL mid_reset got d=%0d q=%0d want d=0 q=0", d, q);
      else passed++;
      apply(1'b0, 16'sd555, -16'sd666, 16'sd0);
      total++;
      if (d !== 16'sd555 || q !== -16'sd666)
         $display("FAIL mid_resume got d=%0d q=%0d want d=555 q=-666", d, q);
      else passed++;
      apply(1'b0, 16'sd1000, 16'sd2000, 16'sd16384);
      total++;
      if (d !== 16'sd2000 || q !== -16'sd1000)
         $display("FAIL mid_next got d=%0d q=%0d want d=2000 q=-1000", d, q);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b1;
      alpha  = '0;
      beta   = '0;
      theta  = '0;
      test_reset();
      test_identity();
      test_quarter();
      test_eighth();
      test_saturation();
      test_midstream_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
